// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames (optional parity bit), each bit held for OVERSAMPLE bclk cycles.
// Every output, including the debug state view, comes straight from a flop.
module uart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       bclk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       tx_cmd,
  output logic       tx_ready,
  output logic       txd,
  output logic [2:0] dbg_state
);

  // Handshake: a byte is accepted on any rising edge where tx_ready is high and
  // tx_cmd is high; tx_cmd is a level request and is not remembered while busy.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  localparam int            TW        = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic          txd_q, txd_d;
  logic          ready_q, ready_d;

  logic          tick_end;
  logic [2:0]    next_idx;
  logic          parity_bit;

  always_comb begin
    tick_end   = (tick_q == TICK_LAST);
    next_idx   = bit_idx_q + 3'd1;
    parity_bit = (^data_q) ^ PARITY_ODD;

    state_d   = state_q;
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    txd_d     = txd_q;
    ready_d   = ready_q;

    case (state_q)
      S_IDLE: begin
        txd_d   = 1'b1;
        ready_d = 1'b1;
        if (tx_cmd) begin
          data_d    = din;
          txd_d     = 1'b0;
          ready_d   = 1'b0;
          tick_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = S_START;
        end
      end

      S_START: begin
        if (tick_end) begin
          tick_d    = '0;
          bit_idx_d = 3'd0;
          txd_d     = data_q[0];
          state_d   = S_DATA;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      S_DATA: begin
        if (tick_end) begin
          tick_d = '0;
          if (bit_idx_q == 3'd7) begin
            // Parity stage is skipped entirely when disabled.
            if (PARITY_EN) begin
              txd_d   = parity_bit;
              state_d = S_PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_idx_d = next_idx;
            txd_d     = data_q[next_idx];
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      S_PARITY: begin
        if (tick_end) begin
          tick_d  = '0;
          txd_d   = 1'b1;
          state_d = S_STOP;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      S_STOP: begin
        if (tick_end) begin
          tick_d  = '0;
          txd_d   = 1'b1;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      default: begin
        tick_d  = '0;
        txd_d   = 1'b1;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge bclk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_idx_q <= 3'd0;
      data_q    <= 8'h00;
      txd_q     <= 1'b1;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      txd_q     <= txd_d;
      ready_q   <= ready_d;
    end
  end

  assign txd       = txd_q;
  assign tx_ready  = ready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a default 8N1 instance and an even-parity instance,
// both at OVERSAMPLE=16, checked cycle by cycle against hand-derived frames.
module tb_uart_tx;

  localparam int OS = 16;

  logic       bclk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx_cmd = 1'b0;
  logic       tx_ready, txd;
  logic [2:0] dbg_state;

  logic [7:0] din_p = 8'h00;
  logic       tx_cmd_p = 1'b0;
  logic       tx_ready_p, txd_p;
  logic [2:0] dbg_state_p;

  int errors = 0;
  int checks = 0;

  always #5 bclk = ~bclk;

  uart_tx #(.OVERSAMPLE(OS)) u_dut (
    .bclk(bclk), .rst(rst), .din(din), .tx_cmd(tx_cmd),
    .tx_ready(tx_ready), .txd(txd), .dbg_state(dbg_state)
  );

  uart_tx #(.OVERSAMPLE(OS), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_par (
    .bclk(bclk), .rst(rst), .din(din_p), .tx_cmd(tx_cmd_p),
    .tx_ready(tx_ready_p), .txd(txd_p), .dbg_state(dbg_state_p)
  );

  // Advance to just after the next rising edge: inputs set afterwards are seen
  // at the following edge, outputs read afterwards reflect this edge.
  task automatic step();
    @(posedge bclk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    tx_cmd = 1'b1;
    din    = 8'h55;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (txd !== 1'b1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: txd=%b tx_ready=%b expected 1 1", txd, tx_ready);
    end
    checks++;
    if (txd_p !== 1'b1 || tx_ready_p !== 1'b1 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold_par: txd_p=%b tx_ready_p=%b state=%0d expected 1 1 0",
               txd_p, tx_ready_p, dbg_state);
    end
    tx_cmd = 1'b0;
    rst    = 1'b1;
    for (int i = 0; i < 500; i++) begin
      step();
      checks++;
      if (txd !== 1'b1 || tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_500 cycle %0d: txd=%b tx_ready=%b expected 1 1", i, txd, tx_ready);
      end
    end
  endtask

  // din=0x65 frame: start, 1,0,1,0,0,1,1,0 LSB first, stop.
  task automatic test_single_frame();
    logic [9:0] frame;
    frame  = 10'b1_0110_0101_0;
    din    = 8'h65;
    tx_cmd = 1'b1;
    step();
    tx_cmd = 1'b0;
    din    = 8'h00;
    for (int k = 0; k < 10 * OS; k++) begin
      checks++;
      if (txd !== frame[k / OS] || tx_ready !== 1'b0) begin
        errors++;
        $display("FAIL single_frame cycle %0d: txd=%b tx_ready=%b expected %b 0",
                 k, txd, tx_ready, frame[k / OS]);
      end
      step();
    end
    checks++;
    if (txd !== 1'b1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_frame_end: txd=%b tx_ready=%b expected 1 1", txd, tx_ready);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [9:0] frame;
    frame  = 10'b1_0110_0101_0;
    din    = 8'h65;
    tx_cmd = 1'b1;
    step();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k <= 10 * OS; k++) begin
        if (k < 10 * OS) begin
          checks++;
          if (txd !== frame[k / OS] || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b frame %0d cycle %0d: txd=%b tx_ready=%b expected %b 0",
                     f, k, txd, tx_ready, frame[k / OS]);
          end
        end else begin
          checks++;
          if (txd !== 1'b1 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap frame %0d: txd=%b tx_ready=%b expected 1 1", f, txd, tx_ready);
          end
        end
        if (f == 1 && k == 10 * OS - 1) tx_cmd = 1'b0;
        step();
      end
    end
    checks++;
    if (txd !== 1'b1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stop: txd=%b tx_ready=%b expected 1 1", txd, tx_ready);
    end
  endtask

  task automatic test_ignore_busy();
    din    = 8'h00;
    tx_cmd = 1'b1;
    step();
    tx_cmd = 1'b0;
    for (int k = 0; k < 10 * OS; k++) begin
      checks++;
      if (txd !== ((k / OS) == 9 ? 1'b1 : 1'b0) || tx_ready !== 1'b0) begin
        errors++;
        $display("FAIL ignore_busy cycle %0d: txd=%b tx_ready=%b expected %b 0",
                 k, txd, tx_ready, ((k / OS) == 9));
      end
      if (k == 40) begin
        din    = 8'hFF;
        tx_cmd = 1'b1;
      end else begin
        tx_cmd = 1'b0;
      end
      step();
    end
    for (int i = 0; i < 3 * OS; i++) begin
      checks++;
      if (txd !== 1'b1 || tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL no_queue cycle %0d: txd=%b tx_ready=%b expected 1 1", i, txd, tx_ready);
      end
      step();
    end
  endtask

  // Abort a 0x3C frame at cycle 70, then send 0xA5: 0, 1,0,1,0,0,1,0,1, 1.
  task automatic test_reset_mid_frame();
    logic [9:0] frame;
    frame  = 10'b1_1010_0101_0;
    din    = 8'h3C;
    tx_cmd = 1'b1;
    step();
    tx_cmd = 1'b0;
    for (int k = 0; k < 70; k++) step();
    rst    = 1'b0;
    tx_cmd = 1'b1;
    step();
    checks++;
    if (txd !== 1'b1 || tx_ready !== 1'b1 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: txd=%b tx_ready=%b state=%0d expected 1 1 0", txd, tx_ready, dbg_state);
    end
    step();
    checks++;
    if (txd !== 1'b1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_hold: txd=%b tx_ready=%b expected 1 1", txd, tx_ready);
    end
    rst = 1'b1;
    din = 8'hA5;
    step();
    tx_cmd = 1'b0;
    din    = 8'h00;
    for (int k = 0; k < 10 * OS; k++) begin
      checks++;
      if (txd !== frame[k / OS] || tx_ready !== 1'b0) begin
        errors++;
        $display("FAIL after_reset cycle %0d: txd=%b tx_ready=%b expected %b 0",
                 k, txd, tx_ready, frame[k / OS]);
      end
      step();
    end
    checks++;
    if (txd !== 1'b1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_end: txd=%b tx_ready=%b expected 1 1", txd, tx_ready);
    end
  endtask

  // 0x07 has three ones, so even parity drives 1 before the stop bit.
  task automatic test_parity();
    logic [10:0] frame;
    frame    = 11'b1_1_0000_0111_0;
    din_p    = 8'h07;
    tx_cmd_p = 1'b1;
    step();
    tx_cmd_p = 1'b0;
    for (int k = 0; k < 11 * OS; k++) begin
      checks++;
      if (txd_p !== frame[k / OS] || tx_ready_p !== 1'b0) begin
        errors++;
        $display("FAIL parity_frame cycle %0d: txd=%b tx_ready=%b expected %b 0",
                 k, txd_p, tx_ready_p, frame[k / OS]);
      end
      if (k == 9 * OS) begin
        checks++;
        if (dbg_state_p !== 3'd3) begin
          errors++;
          $display("FAIL parity_state: state=%0d expected 3", dbg_state_p);
        end
      end
      step();
    end
    checks++;
    if (txd_p !== 1'b1 || tx_ready_p !== 1'b1) begin
      errors++;
      $display("FAIL parity_end: txd=%b tx_ready=%b expected 1 1", txd_p, tx_ready_p);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
